// File: rtl/tx_frame_scheduler_pkg.sv
// Shared definitions for the transmit frame scheduler: FSM encoding,
// frame-type codes, parameter defaults and counter sizing.
package tx_frame_scheduler_pkg;

    localparam int IFG_CYCLES_DEF     = 24;
    localparam int TIMEOUT_CYCLES_DEF = 4095;
    localparam int FRAMEID_W_DEF      = 16;

    // Frame type carried on frm_sel and remembered as last_sel.
    localparam logic SEL_DATA = 1'b0;
    localparam logic SEL_CTRL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_IFG       = 2'd3
    } tx_state_e;

    // Width of one counter able to hold both the gap and the timeout count.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/tx_rr_arb2.sv
// Two-input round-robin selector between the data and control requests.
// req[0] is data, req[1] is control; gnt_sel uses the same encoding.
module tx_rr_arb2
    import tx_frame_scheduler_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_sel,
    output logic       gnt_valid,
    output logic       gnt_sel
);

    // A lone requester wins outright; on a tie the type not served last wins.
    always_comb begin
        gnt_valid = |req;
        gnt_sel   = SEL_DATA;
        if (req[0] && req[1]) begin
            gnt_sel = ~last_sel;
        end else if (req[1]) begin
            gnt_sel = SEL_CTRL;
        end
    end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Transmit frame scheduler: arbitrates data/control frame requests, starts
// the framer, waits for its completion (with a timeout), then enforces the
// inter-frame gap. All state moves on the falling edge of phy_txclk so it
// lines up with the transmit framer.
module tx_frame_scheduler
    import tx_frame_scheduler_pkg::*;
#(
    parameter int IFG_CYCLES     = IFG_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int FRAMEID_W      = FRAMEID_W_DEF
) (
    input  logic                 phy_txclk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 req_data,
    input  logic                 req_ctrl,
    input  logic                 frm_done,
    output logic                 frm_start,
    output logic                 frm_sel,
    output logic [FRAMEID_W-1:0] frm_id,
    output logic                 ack_data,
    output logic                 ack_ctrl,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int               CNT_W  = cnt_width(IFG_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TMO_TC = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] IFG_TC = CNT_W'(IFG_CYCLES - 1);

    tx_state_e            state_q;
    tx_state_e            state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 last_sel_q;
    logic                 frm_sel_q;
    logic                 ack_data_q;
    logic                 ack_ctrl_q;
    logic                 timeout_err_q;
    logic [FRAMEID_W-1:0] frm_id_q;

    logic grant;
    logic done_ok;
    logic tmo_hit;
    logic gnt_valid;
    logic gnt_sel;

    tx_rr_arb2 u_arb (
        .req       ({req_ctrl, req_data}),
        .last_sel  (last_sel_q),
        .gnt_valid (gnt_valid),
        .gnt_sel   (gnt_sel)
    );

    // State register.
    always_ff @(negedge phy_txclk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Moore outputs; completion beats timeout on the terminal count.
    always_comb begin
        state_d   = state_q;
        grant     = 1'b0;
        done_ok   = 1'b0;
        tmo_hit   = 1'b0;
        frm_start = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (enable && gnt_valid) begin
                    grant   = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                frm_start = 1'b1;
                state_d   = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (frm_done) begin
                    done_ok = 1'b1;
                    state_d = ST_IFG;
                end else if (cnt_q == TMO_TC) begin
                    tmo_hit = 1'b1;
                    state_d = ST_IFG;
                end
            end
            ST_IFG: begin
                if (cnt_q == IFG_TC) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Shared counter: ages the frame from START through WAIT_DONE, restarts at
    // the end of the frame and then times the gap in IFG.
    always_ff @(negedge phy_txclk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q == ST_IDLE || done_ok || tmo_hit) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Grant bookkeeping, completion acks, frame ID and the sticky timeout flag.
    always_ff @(negedge phy_txclk) begin
        if (reset) begin
            last_sel_q    <= SEL_CTRL;
            frm_sel_q     <= SEL_DATA;
            ack_data_q    <= 1'b0;
            ack_ctrl_q    <= 1'b0;
            frm_id_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            ack_data_q <= done_ok && (frm_sel_q == SEL_DATA);
            ack_ctrl_q <= done_ok && (frm_sel_q == SEL_CTRL);
            if (grant) begin
                frm_sel_q  <= gnt_sel;
                last_sel_q <= gnt_sel;
            end
            if (done_ok && (frm_sel_q == SEL_DATA)) begin
                frm_id_q <= frm_id_q + FRAMEID_W'(1);
            end
            if (tmo_hit) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign frm_sel     = frm_sel_q;
    assign frm_id      = frm_id_q;
    assign ack_data    = ack_data_q;
    assign ack_ctrl    = ack_ctrl_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: doc/tx_frame_scheduler.md
TX_FRAME_SCHEDULER -- requirements
Module: tx_frame_scheduler

Interface
REQ-001 SHALL have parameter IFG_CYCLES, default 24, inter-frame gap in phy_txclk cycles (96 bit times on MII).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4095, maximum cycles from frm_start to frm_done.
REQ-003 SHALL have parameter FRAMEID_W, default 16, width of the frame ID.
REQ-004 phy_txclk  in  1  MII transmit clock; sole clock; all state updates on its falling edge, matching the transmit framer.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  level; when low, no new frame is granted.
REQ-007 req_data  in  1  level; a payload buffer half is full and ready to send.
REQ-008 req_ctrl  in  1  level; a control ("need-data") frame is requested.
REQ-009 frm_done  in  1  one-cycle pulse from the framer at the end of the CRC nibbles.
REQ-010 frm_start  out  1  one-cycle pulse that starts the framer.
REQ-011 frm_sel  out  1  frame type for the current grant: 0 = data, 1 = control; held from frm_start until the next grant.
REQ-012 frm_id  out  FRAMEID_W  ID inserted into the frame header.
REQ-013 ack_data / ack_ctrl  out  1 each  one-cycle pulse consuming the served request.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 timeout_err  out  1  sticky framer-timeout flag.

Function
REQ-016 SHALL implement the states IDLE, START, WAIT_DONE and IFG.
REQ-017 IDLE -> START SHALL occur when enable=1 and (req_data or req_ctrl); the selection SHALL be registered into frm_sel on the same edge.
REQ-018 Arbitration: a single pending request SHALL win; when both are pending, the type opposite to last_sel SHALL win (round-robin); last_sel SHALL update at grant.
REQ-019 START SHALL last exactly one cycle with frm_start=1, then go to WAIT_DONE.
REQ-020 Latency: a request sampled in IDLE at cycle n SHALL produce frm_start at cycle n+1.
REQ-021 In WAIT_DONE, frm_done=1 SHALL cause IFG on the next edge and a one-cycle pulse on ack_data or ack_ctrl, according to frm_sel, in the following cycle.
REQ-022 frm_done SHALL be ignored in IDLE, START and IFG.
REQ-023 frm_id SHALL increment by 1 (modulo 2^FRAMEID_W, wrap from all-ones to 0) on each completed data frame, one cycle after frm_done; control frames SHALL NOT change it.
REQ-024 A WAIT_DONE cycle counter SHALL clear at START; when it reaches TIMEOUT_CYCLES without frm_done, the block SHALL set timeout_err, go to IFG, and issue no ack and no frm_id increment.
REQ-025 IFG SHALL last exactly IFG_CYCLES cycles, then go to IDLE; new requests SHALL be held off during IFG.
REQ-026 Minimum spacing SHALL be: frm_done at cycle d -> next frm_start no earlier than d+IFG_CYCLES+2.
REQ-027 enable falling during START, WAIT_DONE or IFG SHALL NOT abort the frame in flight; only the next grant is blocked.
REQ-028 A request deasserting after grant SHALL NOT cancel the frame.
REQ-029 frm_done coinciding with the timeout terminal count SHALL be treated as completion (ack issued, no error).
REQ-030 timeout_err SHALL clear only on reset.

Reset
REQ-031 Reset SHALL force IDLE and drive frm_start, frm_sel, ack_data, ack_ctrl, busy, timeout_err and frm_id to 0; counters SHALL clear.
REQ-032 Reset SHALL set last_sel=1, so a data request wins the first tie.
REQ-033 Reset asserted mid-frame SHALL take effect on the next edge, with no ack pulse.

Structure
REQ-034 The state encoding and the IFG_CYCLES, TIMEOUT_CYCLES and FRAMEID_W defaults SHALL reside in the shared tx package/include.
REQ-035 The two-input round-robin selector SHALL be a sub-module tx_rr_arb2 (inputs: req[1:0], last_sel; outputs: gnt_valid, gnt_sel).
REQ-036 The IFG and timeout counters SHALL share one counter sized for max(IFG_CYCLES, TIMEOUT_CYCLES).

Verification
REQ-037 Reset, then req_data=1 at cycle 10 -> frm_start at 11 with frm_sel=0; frm_done at 200 -> ack_data at 201, frm_id=1 at 201.
REQ-038 req_data and req_ctrl held together -> grants alternate data, ctrl, data, ctrl; frm_id increments only on data frames.
REQ-039 Back-to-back with frm_done at cycle d -> next frm_start exactly at d+26 (IFG_CYCLES=24).
REQ-040 No frm_done after frm_start -> timeout_err=1 at TIMEOUT_CYCLES, no ack, busy falls after 24 IFG cycles.
REQ-041 enable dropped during WAIT_DONE -> frame completes with ack; no frm_start while enable=0.
REQ-042 frm_id preset to 0xFFFF, then a data frame completes -> frm_id=0x0000.
